pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and fetch stage sitting directly upstream of the 4K x 8 ROM (`rom_mem`). Generates the 12-bit ROM address from an internal program counter, captures the returned 8-bit byte, splits it into instruction (high nibble) and operand (low nibble), and flags each captured byte with a one-cycle `valid`. Supports free-running fetch, single-step fetch, and a synchronous PC load for jumps.

## Interface
Parameters:
- `ADDR_W`, 12, PC/ROM address width (ROM depth 2^ADDR_W).
- `DATA_W`, 8, ROM data width; must be even. `instr` is the upper half, `oprnd` the lower half.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; while high, fetch continuously.
- `step`  in  1  pulse; one fetch when IDLE and `run` low.
- `load`  in  1  pulse; load PC from `load_addr`.
- `load_addr`  in  ADDR_W  jump target.
- `rom_addr`  out  ADDR_W  address to ROM; equals the PC register.
- `rom_data`  in  DATA_W  ROM read data; combinational (same-cycle) read.
- `instr`  out  DATA_W/2  captured `rom_data[DATA_W-1:DATA_W/2]`.
- `oprnd`  out  DATA_W/2  captured `rom_data[DATA_W/2-1:0]`.
- `valid`  out  1  high for exactly the cycle after a capture.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, FETCH, LATCH.
- IDLE: `run`=1 → FETCH; else `step`=1 → FETCH; else stay.
- FETCH: `rom_addr`=PC stable for the full cycle. On the edge leaving FETCH, capture `instr`/`oprnd` from `rom_data`, set `valid`, PC ← PC+1; go to LATCH.
- LATCH: `valid`=1. Next edge: `run`=1 → FETCH, else IDLE. A `step` entry always returns to IDLE unless `run` has been raised.
- PC increment wraps modulo 2^ADDR_W (0xFFF → 0x000) with no flag.
- `load` (any state): PC ← `load_addr`; no capture on that edge; `valid` ← 0; next state FETCH if `run`=1, else IDLE. `load` has priority over capture, increment, and `step`.
- `run` and `step` both high in IDLE: treated as `run`.
- `step` outside IDLE: ignored; it is not queued.
- `instr`/`oprnd` hold their last captured value until the next capture.
- Reset: PC=0, `rom_addr`=0, `instr`=0, `oprnd`=0, `valid`=0, `busy`=0, state IDLE. Reset overrides `load`. Reset mid-fetch discards the in-flight fetch.

## Timing
- Throughput: 1 byte per 2 cycles in run mode.
- Latency: `run` sampled high at edge N in IDLE → FETCH during N..N+1 → capture at edge N+1 → `valid` high during N+1..N+2, with `rom_addr` already incremented.
- `valid` never stays high for two consecutive cycles.
- After `load` at edge N with `run`=1: `rom_addr`=`load_addr` from N. Capture of that address happens at edge N+1.
- All outputs are registered or pure functions of state/PC. No combinational path from inputs to outputs.

## Structure
- Package `pc_fetch_pkg`: state enum (IDLE/FETCH/LATCH), default `ADDR_W`/`DATA_W` constants, PC reset value (0).
- Sub-module `pc_counter`: ADDR_W-bit register with synchronous reset, `load` and `inc` inputs, load priority over increment, wrap on overflow. `pc_fetch` instantiates it and holds the FSM and capture register.

## Test plan
ROM image: 0x000=A5, 0x001=3C, 0x002=7E, 0x100=12, 0x101=F0, 0xFFF=81.

- Reset with `run`=0 → `rom_addr`=000, `instr`=0, `oprnd`=0, `valid`=0, `busy`=0.
- `run` held high from reset release for 6 cycles → `valid` pulses on cycles 2, 4, 6, giving (A,5), (3,C), (7,E); `rom_addr` ends at 003.
- `run`=0 and one `step` pulse → exactly one `valid` with (A,5), `rom_addr`=001, FSM returns to IDLE. A second `step` pulsed while `busy`=1 is ignored.
- `load`=1, `load_addr`=100 during LATCH while running → no `valid` on the following cycle. Next captures are (1,2) then (F,0).
- `load_addr`=FFF followed by one `step` → captures (8,1); `rom_addr` wraps to 000.
- `reset` asserted during FETCH with `load` also high → all outputs return to their reset values, PC=000, no capture.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / fetch stage.
package pc_fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 12;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned PC_RESET_VAL = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/pc_fetch_counter.sv
// Program counter: synchronous reset, load has priority over increment, wraps on overflow.
module pc_counter
    import pc_fetch_pkg::*;
#(
    parameter int unsigned W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] pc
);

    // PC register; natural W-bit rollover gives the modulo-2^W wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= W'(PC_RESET_VAL);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: drives ROM address from the PC, captures the returned byte as instr/oprnd.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    input  logic                load,
    input  logic [ADDR_W-1:0]   load_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [DATA_W/2-1:0] instr,
    output logic [DATA_W/2-1:0] oprnd,
    output logic                valid,
    output logic                busy
);

    localparam int unsigned HALF_W = DATA_W / 2;

    state_t state;
    state_t state_next;
    logic   capture_c;

    pc_counter #(.W(ADDR_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .inc      (capture_c),
        .load_val (load_addr),
        .pc       (rom_addr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load overrides normal sequencing and suppresses the capture
    always_comb begin
        state_next = state;
        capture_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run || step) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_LATCH;
                capture_c  = 1'b1;
            end
            ST_LATCH: begin
                state_next = run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (load) begin
            state_next = run ? ST_FETCH : ST_IDLE;
            capture_c  = 1'b0;
        end
    end

    // Capture register and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= HALF_W'(0);
            oprnd <= HALF_W'(0);
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= capture_c;
            busy  <= (state_next != ST_IDLE);
            if (capture_c) begin
                instr <= rom_data[DATA_W-1:HALF_W];
                oprnd <= rom_data[HALF_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed vector table plus randomized run against a behavioural model.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        load;
    logic [11:0] load_addr;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        valid;
    logic        busy;

    logic [7:0]  rom [0:4095];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit r;
        bit rn;
        bit st;
        bit ld;
        int la;
        int ra;
        int ins;
        int op;
        int vl;
        int bs;
    } vec_t;

    vec_t vecs[$];

    pc_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .load      (load),
        .load_addr (load_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .instr     (instr),
        .oprnd     (oprnd),
        .valid     (valid),
        .busy      (busy)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit rn, input bit st, input bit ld, input int la,
                       input int ra, input int ins, input int op, input int vl, input int bs);
        vec_t v;
        v.r = r; v.rn = rn; v.st = st; v.ld = ld; v.la = la;
        v.ra = ra; v.ins = ins; v.op = op; v.vl = vl; v.bs = bs;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input int idx, input int ra, input int ins, input int op,
                                 input int vl, input int bs);
        check("rom_addr", idx, int'(rom_addr), ra);
        check("instr",    idx, int'(instr),    ins);
        check("oprnd",    idx, int'(oprnd),    op);
        check("valid",    idx, int'(valid),    vl);
        check("busy",     idx, int'(busy),     bs);
    endtask

    // Behavioural model state: mode 0 = waiting, 1 = address on bus, 2 = byte presented
    int m_pc, m_mode, m_cap, m_valid;

    task automatic model_edge(input bit r, input bit rn, input bit st, input bit ld, input int la);
        if (r) begin
            m_pc = 0; m_mode = 0; m_cap = 0; m_valid = 0;
        end else if (ld) begin
            m_pc = la; m_valid = 0; m_mode = rn ? 1 : 0;
        end else if (m_mode == 1) begin
            m_cap = int'(rom[m_pc]); m_pc = (m_pc + 1) % 4096; m_valid = 1; m_mode = 2;
        end else if (m_mode == 2) begin
            m_valid = 0; m_mode = rn ? 1 : 0;
        end else begin
            m_valid = 0; m_mode = (rn || st) ? 1 : 0;
        end
    endtask

    initial begin
        int prev_valid;

        for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);
        rom[12'h000] = 8'hA5; rom[12'h001] = 8'h3C; rom[12'h002] = 8'h7E;
        rom[12'h100] = 8'h12; rom[12'h101] = 8'hF0; rom[12'hFFF] = 8'h81;

        //   r  run st ld la      ra      in   op   v  b
        add(1, 0, 0, 0, 0,      'h000, 0,   0,   0, 0);
        add(1, 0, 0, 0, 0,      'h000, 0,   0,   0, 0);
        add(0, 1, 0, 0, 0,      'h000, 0,   0,   0, 1);
        add(0, 1, 0, 0, 0,      'h001, 'hA, 'h5, 1, 1);
        add(0, 1, 0, 0, 0,      'h001, 'hA, 'h5, 0, 1);
        add(0, 1, 0, 0, 0,      'h002, 'h3, 'hC, 1, 1);
        add(0, 1, 0, 0, 0,      'h002, 'h3, 'hC, 0, 1);
        add(0, 1, 0, 0, 0,      'h003, 'h7, 'hE, 1, 1);
        add(0, 0, 0, 0, 0,      'h003, 'h7, 'hE, 0, 0);
        add(1, 0, 0, 0, 0,      'h000, 0,   0,   0, 0);
        add(0, 0, 1, 0, 0,      'h000, 0,   0,   0, 1);
        add(0, 0, 1, 0, 0,      'h001, 'hA, 'h5, 1, 1);
        add(0, 0, 1, 0, 0,      'h001, 'hA, 'h5, 0, 0);
        add(0, 0, 0, 0, 0,      'h001, 'hA, 'h5, 0, 0);
        add(0, 0, 0, 0, 0,      'h001, 'hA, 'h5, 0, 0);
        add(0, 1, 0, 0, 0,      'h001, 'hA, 'h5, 0, 1);
        add(0, 1, 0, 0, 0,      'h002, 'h3, 'hC, 1, 1);
        add(0, 1, 0, 1, 'h100,  'h100, 'h3, 'hC, 0, 1);
        add(0, 1, 0, 0, 0,      'h101, 'h1, 'h2, 1, 1);
        add(0, 1, 0, 0, 0,      'h101, 'h1, 'h2, 0, 1);
        add(0, 1, 0, 0, 0,      'h102, 'hF, 'h0, 1, 1);
        add(0, 0, 0, 0, 0,      'h102, 'hF, 'h0, 0, 0);
        add(0, 0, 0, 1, 'hFFF,  'hFFF, 'hF, 'h0, 0, 0);
        add(0, 0, 1, 0, 0,      'hFFF, 'hF, 'h0, 0, 1);
        add(0, 0, 0, 0, 0,      'h000, 'h8, 'h1, 1, 1);
        add(0, 0, 0, 0, 0,      'h000, 'h8, 'h1, 0, 0);
        add(0, 1, 0, 0, 0,      'h000, 'h8, 'h1, 0, 1);
        add(1, 1, 0, 1, 'h100,  'h000, 0,   0,   0, 0);
        add(0, 0, 0, 0, 0,      'h000, 0,   0,   0, 0);

        reset = 1'b1; run = 1'b0; step = 1'b0; load = 1'b0; load_addr = 12'h000;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].r;
            run       = vecs[i].rn;
            step      = vecs[i].st;
            load      = vecs[i].ld;
            load_addr = 12'(vecs[i].la);
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].ra, vecs[i].ins, vecs[i].op, vecs[i].vl, vecs[i].bs);
        end

        // Randomized traffic against the behavioural model
        m_pc = 0; m_mode = 0; m_cap = 0; m_valid = 0;
        prev_valid = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = (c == 0) || ($urandom_range(0, 99) == 0);
            run   = ($urandom_range(0, 1) == 1);
            step  = ($urandom_range(0, 2) == 0);
            load  = ($urandom_range(0, 19) == 0);
            load_addr = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            model_edge(reset, run, step, load, int'(load_addr));
            @(posedge clk);
            #1;
            check_outputs(1000 + c, m_pc, (m_cap >> 4) & 'hF, m_cap & 'hF, m_valid,
                          (m_mode != 0) ? 1 : 0);
            check("valid_twice", 1000 + c, (prev_valid == 1 && valid == 1'b1) ? 1 : 0, 0);
            prev_valid = int'(valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
